// File: rtl/glcd_bus_sequencer_if.sv
// Request/LCD bus bundle for glcd_bus_sequencer.
// The requester side (game renderer, score overlay, plus whoever watches the
// LCD pins) uses the master modport; the sequencer itself uses slave.
interface glcd_bus_sequencer_if;
    logic [1:0]  req_valid;
    logic [5:0]  req_page;
    logic [13:0] req_col;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        init_done;
    logic        busy;
    logic        lcd_e;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        cs1;
    logic        cs2;
    logic        lcd_rst;
    logic [7:0]  lcd_data;

    modport master (
        output req_valid, req_page, req_col, req_data,
        input  req_ready, init_done, busy,
        input  lcd_e, lcd_rs, lcd_rw, cs1, cs2, lcd_rst, lcd_data
    );

    modport slave (
        input  req_valid, req_page, req_col, req_data,
        output req_ready, init_done, busy,
        output lcd_e, lcd_rs, lcd_rw, cs1, cs2, lcd_rst, lcd_data
    );
endinterface

// File: rtl/glcd_bus_sequencer.sv
// KS0108-style dual-chip 128x64 GLCD bus sequencer.
// Runs the LCD power-up sequence, then round-robins two byte-write requesters
// onto the bus as set-page / set-column / data-write strobed bus cycles.
// Optional feature: define GLCD_ADDR_CACHE_EN to track each chip's page and
// column so redundant address commands are skipped.
module glcd_bus_sequencer #(
    parameter int E_SETUP    = 2,
    parameter int E_HIGH     = 4,
    parameter int E_HOLD     = 2,
    parameter int RST_CYCLES = 16,
    parameter int INIT_WAIT  = 64
) (
    input logic                 clk,
    input logic                 rst,
    glcd_bus_sequencer_if.slave bus
);
    localparam int BC_LEN = E_SETUP + E_HIGH + E_HOLD;
    localparam int CNT_W  = 16;

    typedef enum logic [3:0] {
        RST_HOLD, RST_WAIT, INIT_ON, INIT_LINE, IDLE, GRANT, SET_PAGE, SET_COL, WRITE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             bc_last;
    logic             e_nxt;

    logic [1:0] req_ready;
    logic       init_done, busy, lcd_e, lcd_rs, cs1, cs2, lcd_rst;
    logic [7:0] lcd_data;

    logic       last_grant;
    logic [5:0] lat_y;
    logic [7:0] lat_data;
    logic       skip_col_q;

    logic       win;
    logic [2:0] g_page;
    logic [6:0] g_col;
    logic [7:0] g_data;
    logic       skip_page;
    logic       skip_col;

    // Shared bus-cycle timing: E is high for counts E_SETUP..E_SETUP+E_HIGH-1.
    assign cnt_nxt = cnt + 1'b1;
    assign bc_last = (cnt == CNT_W'(BC_LEN - 1));
    assign e_nxt   = (cnt_nxt >= CNT_W'(E_SETUP)) && (cnt_nxt < CNT_W'(E_SETUP + E_HIGH));

    // Round-robin winner and its request fields; skip flags come from the cache.
    always_comb begin
        if (bus.req_valid == 2'b11) begin
            win = ~last_grant;
        end else begin
            win = bus.req_valid[1];
        end
        g_page = win ? bus.req_page[5:3]  : bus.req_page[2:0];
        g_col  = win ? bus.req_col[13:7]  : bus.req_col[6:0];
        g_data = win ? bus.req_data[15:8] : bus.req_data[7:0];
    end

`ifdef GLCD_ADDR_CACHE_EN
    logic [1:0] cache_valid;
    logic [2:0] cache_page [2];
    logic [5:0] cache_y    [2];

    // A hit needs a valid entry for the addressed chip and a matching field.
    always_comb begin
        skip_page = cache_valid[g_col[6]] && (cache_page[g_col[6]] == g_page);
        skip_col  = cache_valid[g_col[6]] && (cache_y[g_col[6]] == g_col[5:0]);
    end

    // The cache is committed at grant: the page/column commands and the write
    // that follow are never separated, and a reset mid-transfer clears it anyway.
    // The stored y is the chip's post-write column, which wraps within the chip.
    always_ff @(posedge clk) begin
        if (rst || state == RST_HOLD) begin
            cache_valid <= 2'b00;
        end else if (state == GRANT && (|bus.req_valid)) begin
            cache_valid[g_col[6]] <= 1'b1;
            cache_page[g_col[6]]  <= g_page;
            cache_y[g_col[6]]     <= g_col[5:0] + 6'd1;
        end
    end
`else
    assign skip_page = 1'b0;
    assign skip_col  = 1'b0;
`endif

    // Main sequencer: reset/init, arbitration and bus-cycle generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RST_HOLD;
            cnt        <= '0;
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_data   <= 8'h00;
            cs1        <= 1'b0;
            cs2        <= 1'b0;
            lcd_rst    <= 1'b0;
            req_ready  <= 2'b00;
            init_done  <= 1'b0;
            busy       <= 1'b1;
            last_grant <= 1'b1;
            lat_y      <= 6'd0;
            lat_data   <= 8'h00;
            skip_col_q <= 1'b0;
        end else begin
            req_ready <= 2'b00;
            case (state)
                RST_HOLD: begin
                    if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                        state   <= RST_WAIT;
                        cnt     <= '0;
                        lcd_rst <= 1'b1;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                RST_WAIT: begin
                    if (cnt == CNT_W'(INIT_WAIT - 1)) begin
                        state    <= INIT_ON;
                        cnt      <= '0;
                        cs1      <= 1'b1;
                        cs2      <= 1'b1;
                        lcd_rs   <= 1'b0;
                        lcd_data <= 8'h3F;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                INIT_ON: begin
                    if (bc_last) begin
                        state    <= INIT_LINE;
                        cnt      <= '0;
                        lcd_e    <= 1'b0;
                        lcd_data <= 8'hC0;
                    end else begin
                        cnt   <= cnt_nxt;
                        lcd_e <= e_nxt;
                    end
                end
                INIT_LINE: begin
                    if (bc_last) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        lcd_e     <= 1'b0;
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt   <= cnt_nxt;
                        lcd_e <= e_nxt;
                    end
                end
                IDLE: begin
                    if (|bus.req_valid) begin
                        state <= GRANT;
                        busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (|bus.req_valid) begin
                        req_ready  <= win ? 2'b10 : 2'b01;
                        last_grant <= win;
                        lat_y      <= g_col[5:0];
                        lat_data   <= g_data;
                        skip_col_q <= skip_col;
                        cs1        <= ~g_col[6];
                        cs2        <= g_col[6];
                        cnt        <= '0;
                        lcd_e      <= 1'b0;
                        if (!skip_page) begin
                            state    <= SET_PAGE;
                            lcd_rs   <= 1'b0;
                            lcd_data <= {5'b10111, g_page};
                        end else if (!skip_col) begin
                            state    <= SET_COL;
                            lcd_rs   <= 1'b0;
                            lcd_data <= {2'b01, g_col[5:0]};
                        end else begin
                            state    <= WRITE;
                            lcd_rs   <= 1'b1;
                            lcd_data <= g_data;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SET_PAGE: begin
                    if (bc_last) begin
                        cnt   <= '0;
                        lcd_e <= 1'b0;
                        if (!skip_col_q) begin
                            state    <= SET_COL;
                            lcd_rs   <= 1'b0;
                            lcd_data <= {2'b01, lat_y};
                        end else begin
                            state    <= WRITE;
                            lcd_rs   <= 1'b1;
                            lcd_data <= lat_data;
                        end
                    end else begin
                        cnt   <= cnt_nxt;
                        lcd_e <= e_nxt;
                    end
                end
                SET_COL: begin
                    if (bc_last) begin
                        state    <= WRITE;
                        cnt      <= '0;
                        lcd_e    <= 1'b0;
                        lcd_rs   <= 1'b1;
                        lcd_data <= lat_data;
                    end else begin
                        cnt   <= cnt_nxt;
                        lcd_e <= e_nxt;
                    end
                end
                WRITE: begin
                    if (bc_last) begin
                        state <= IDLE;
                        cnt   <= '0;
                        lcd_e <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt_nxt;
                        lcd_e <= e_nxt;
                    end
                end
                default: begin
                    state <= RST_HOLD;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.init_done = init_done;
    assign bus.busy      = busy;
    assign bus.lcd_e     = lcd_e;
    assign bus.lcd_rs    = lcd_rs;
    assign bus.lcd_rw    = 1'b0;
    assign bus.cs1       = cs1;
    assign bus.cs2       = cs2;
    assign bus.lcd_rst   = lcd_rst;
    assign bus.lcd_data  = lcd_data;
endmodule

// File: tb/tb_glcd_bus_sequencer.sv
// Directed self-checking bench for glcd_bus_sequencer with short timing
// parameters. Expectations follow GLCD_ADDR_CACHE_EN when it is defined.
module tb_glcd_bus_sequencer;
    localparam int E_SETUP    = 1;
    localparam int E_HIGH     = 2;
    localparam int E_HOLD     = 1;
    localparam int RST_CYCLES = 4;
    localparam int INIT_WAIT  = 8;

    typedef struct packed {
        logic       rs;
        logic       cs1;
        logic       cs2;
        logic [7:0] data;
        logic [7:0] hi;
    } bc_t;

    logic clk = 1'b0;
    logic rst;

    glcd_bus_sequencer_if bus ();

    glcd_bus_sequencer #(
        .E_SETUP    (E_SETUP),
        .E_HIGH     (E_HIGH),
        .E_HOLD     (E_HOLD),
        .RST_CYCLES (RST_CYCLES),
        .INIT_WAIT  (INIT_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;

    bc_t got_q[$];
    bc_t exp_q[$];
    int  grant_q[$];
    int  both_count = 0;

    logic       e_prev = 1'b0;
    logic [7:0] hi_cnt = 8'd0;
    bc_t        cap;

    bit         m_valid [2];
    logic [2:0] m_page  [2];
    logic [5:0] m_y     [2];

    // Clock generation.
    always #5 clk = ~clk;

    // Bus monitor: records each strobed cycle with its E-high length, plus grants.
    always @(negedge clk) begin
        if (bus.lcd_e && !e_prev) begin
            cap    = '{bus.lcd_rs, bus.cs1, bus.cs2, bus.lcd_data, 8'd0};
            hi_cnt = 8'd1;
        end else if (bus.lcd_e) begin
            hi_cnt = hi_cnt + 8'd1;
        end else if (e_prev) begin
            cap.hi = hi_cnt;
            got_q.push_back(cap);
        end
        e_prev = bus.lcd_e;
        if (bus.req_ready == 2'b11) both_count++;
        if (bus.req_ready[0]) grant_q.push_back(0);
        else if (bus.req_ready[1]) grant_q.push_back(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic v, input logic [2:0] page,
                                 input logic [6:0] col, input logic [7:0] data);
        if (port == 0) begin
            bus.req_valid[0]  = v;
            bus.req_page[2:0] = page;
            bus.req_col[6:0]  = col;
            bus.req_data[7:0] = data;
        end else begin
            bus.req_valid[1]   = v;
            bus.req_page[5:3]  = page;
            bus.req_col[13:7]  = col;
            bus.req_data[15:8] = data;
        end
    endtask

    task automatic pushExp(input logic rs, input logic c1, input logic c2, input logic [7:0] data);
        exp_q.push_back('{rs, c1, c2, data, 8'(E_HIGH)});
    endtask

    task automatic resetModel();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            m_page[i]  = 3'd0;
            m_y[i]     = 6'd0;
        end
    endtask

    // Expected bus cycles for one request, from the LCD's view of each chip.
    task automatic expectXfer(input logic [2:0] page, input logic [6:0] col, input logic [7:0] data);
        int   chip;
        logic c1, c2;
        chip = int'(col[6]);
        c1   = ~col[6];
        c2   = col[6];
`ifdef GLCD_ADDR_CACHE_EN
        if (!(m_valid[chip] && m_page[chip] == page)) pushExp(1'b0, c1, c2, 8'hB8 | {5'd0, page});
        if (!(m_valid[chip] && m_y[chip] == col[5:0])) pushExp(1'b0, c1, c2, 8'h40 | {2'd0, col[5:0]});
`else
        pushExp(1'b0, c1, c2, 8'hB8 | {5'd0, page});
        pushExp(1'b0, c1, c2, 8'h40 | {2'd0, col[5:0]});
`endif
        pushExp(1'b1, c1, c2, data);
        m_valid[chip] = 1'b1;
        m_page[chip]  = page;
        m_y[chip]     = col[5:0] + 6'd1;
    endtask

    task automatic compareBus(input string tag);
        checkOutput({tag, "_bc_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checkOutput($sformatf("%s_bc%0d_data", tag, i), 32'(got_q[i].data), 32'(exp_q[i].data));
            checkOutput($sformatf("%s_bc%0d_rs_cs", tag, i),
                        32'({got_q[i].rs, got_q[i].cs1, got_q[i].cs2}),
                        32'({exp_q[i].rs, exp_q[i].cs1, exp_q[i].cs2}));
            checkOutput($sformatf("%s_bc%0d_ehigh", tag, i), 32'(got_q[i].hi), 32'(exp_q[i].hi));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Negedges from now until lcd_rst is seen high (bounded).
    task automatic waitRstHigh(output int n);
        n = 0;
        while (n < 100 && bus.lcd_rst !== 1'b1) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic waitInitDone(input string tag);
        int n;
        n = 0;
        while (n < 200 && bus.init_done !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_init_done"}, 32'(bus.init_done), 32'd1);
        checkOutput({tag, "_busy_after_init"}, 32'(bus.busy), 32'd0);
    endtask

    // One request from a single port: hold until accepted, then wait for IDLE.
    task automatic runRequest(input int port, input logic [2:0] page, input logic [6:0] col,
                              input logic [7:0] data, output int cycles);
        bit got;
        applyStimulus(port, 1'b1, page, col, data);
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready[port]) got = 1'b1;
        end
        checkOutput($sformatf("granted_p%0d", port), 32'(got), 32'd1);
        applyStimulus(port, 1'b0, 3'd0, 7'd0, 8'd0);
        cycles = 0;
        while (bus.busy && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("back_to_idle", 32'(bus.busy), 32'd0);
        expectXfer(page, col, data);
    endtask

    // Watchdog so the bench cannot hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        int  n;
        int  cyc;
        int  seen;
        bit  found;

        resetModel();
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_page  = '0;
        bus.req_col   = '0;
        bus.req_data  = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_lcd_e",     32'(bus.lcd_e),     32'd0);
        checkOutput("rst_lcd_rs",    32'(bus.lcd_rs),    32'd0);
        checkOutput("rst_lcd_rw",    32'(bus.lcd_rw),    32'd0);
        checkOutput("rst_lcd_data",  32'(bus.lcd_data),  32'd0);
        checkOutput("rst_cs",        32'({bus.cs1, bus.cs2}), 32'd0);
        checkOutput("rst_lcd_rst",   32'(bus.lcd_rst),   32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_init_done", 32'(bus.init_done), 32'd0);
        checkOutput("rst_busy",      32'(bus.busy),      32'd1);

        // Power-up: lcd_rst low for RST_CYCLES, then first E after INIT_WAIT+E_SETUP.
        rst = 1'b0;
        waitRstHigh(n);
        checkOutput("lcd_rst_low_cycles", 32'(n), 32'(RST_CYCLES));
        n = 0;
        while (n < 100 && bus.lcd_e !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        checkOutput("first_e_delay", 32'(n), 32'(INIT_WAIT + E_SETUP));
        waitInitDone("init");
        pushExp(1'b0, 1'b1, 1'b1, 8'h3F);
        pushExp(1'b0, 1'b1, 1'b1, 8'hC0);
        compareBus("init");

        // Single port-0 write.
        grant_q.delete();
        runRequest(0, 3'd3, 7'd10, 8'hA5, cyc);
        checkOutput("p0_busy_cycles", 32'(cyc), 32'(3 * (E_SETUP + E_HIGH + E_HOLD)));
        checkOutput("p0_grant_count", 32'(grant_q.size()), 32'd1);
        if (grant_q.size() > 0) checkOutput("p0_grant_port", 32'(grant_q[0]), 32'd0);
        compareBus("p0");

        // Single port-1 write on the second chip.
        grant_q.delete();
        runRequest(1, 3'd2, 7'd100, 8'h22, cyc);
        checkOutput("p1_grant_count", 32'(grant_q.size()), 32'd1);
        compareBus("p1");

        // Both ports held valid: grants must alternate starting with port 0.
        grant_q.delete();
        both_count = 0;
        applyStimulus(0, 1'b1, 3'd1, 7'd5,   8'h11);
        applyStimulus(1, 1'b1, 3'd2, 7'd100, 8'h22);
        seen = 0;
        for (int i = 0; i < 400 && seen < 4; i++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) seen++;
        end
        applyStimulus(0, 1'b0, 3'd0, 7'd0, 8'd0);
        applyStimulus(1, 1'b0, 3'd0, 7'd0, 8'd0);
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rr_idle", 32'(bus.busy), 32'd0);
        checkOutput("rr_grant_count", 32'(grant_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_q.size(); i++)
            checkOutput($sformatf("rr_grant%0d", i), 32'(grant_q[i]), 32'(i % 2));
        checkOutput("rr_both_ready", 32'(both_count), 32'd0);
        for (int i = 0; i < 2; i++) begin
            expectXfer(3'd1, 7'd5,   8'h11);
            expectXfer(3'd2, 7'd100, 8'h22);
        end
        compareBus("rr");

        // Consecutive columns and the in-chip wrap from 63 back to 0.
        runRequest(0, 3'd3, 7'd10, 8'h01, cyc);
        compareBus("seq_col10");
        runRequest(0, 3'd3, 7'd11, 8'h02, cyc);
        compareBus("seq_col11");
        runRequest(0, 3'd3, 7'd63, 8'h03, cyc);
        compareBus("seq_col63");
        runRequest(0, 3'd3, 7'd0, 8'h04, cyc);
        compareBus("seq_col0");

        // Reset while E is high during the data write.
        applyStimulus(0, 1'b1, 3'd5, 7'd20, 8'h5A);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (bus.req_ready[0]) applyStimulus(0, 1'b0, 3'd0, 7'd0, 8'd0);
            if (bus.lcd_e && bus.lcd_rs) found = 1'b1;
        end
        checkOutput("midwrite_reached", 32'(found), 32'd1);
        applyStimulus(0, 1'b0, 3'd0, 7'd0, 8'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_lcd_e",     32'(bus.lcd_e),     32'd0);
        checkOutput("abort_lcd_rst",   32'(bus.lcd_rst),   32'd0);
        checkOutput("abort_init_done", 32'(bus.init_done), 32'd0);
        checkOutput("abort_busy",      32'(bus.busy),      32'd1);
        rst = 1'b0;
        waitRstHigh(n);
        checkOutput("reinit_lcd_rst_low_cycles", 32'(n), 32'(RST_CYCLES));
        got_q.delete();
        exp_q.delete();
        resetModel();
        waitInitDone("reinit");
        pushExp(1'b0, 1'b1, 1'b1, 8'h3F);
        pushExp(1'b0, 1'b1, 1'b1, 8'hC0);
        compareBus("reinit");

        // After re-init the address cache must be empty again.
        runRequest(0, 3'd3, 7'd0, 8'h77, cyc);
        compareBus("post_reinit");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
